// File: rtl/rr_mux_arbiter_if.sv
// Request/response bundle between N_REQ producers, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface rr_mux_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered N-to-1 mux between N_REQ valid/ready requesters.
// The just-granted requester drops to lowest priority; output register refills while draining.
module rr_mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    rr_mux_arbiter_if.slave   bus
);
    localparam int SRC_W = $clog2(N_REQ);

    // Rotate requests so ptr sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] req,
                                                  input logic [SRC_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [N_REQ-1:0]   rot_gnt;
        dbl     = {req, req} >> ptr;
        rot     = dbl[N_REQ-1:0];
        rot_gnt = rot & (~rot + N_REQ'(1));
        dbl     = {rot_gnt, rot_gnt} << ptr;
        return dbl[2*N_REQ-1:N_REQ];
    endfunction

    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;

    logic             load;
    logic [N_REQ-1:0] gnt;
    logic [SRC_W-1:0] gidx;
    logic [WIDTH-1:0] mux_data;
    logic [N_REQ-1:0] req_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        load        = !out_valid_q || bus.out_ready;
        gnt         = rr_grant(bus.req_valid, ptr_q);
        gidx        = '0;
        mux_data    = '0;
        req_ready   = '0;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gidx     = gidx | SRC_W'(i);
                mux_data = mux_data | bus.req_data[i*WIDTH +: WIDTH];
            end
        end

        if (load) begin
            if (|gnt) begin
                req_ready   = rst ? '0 : gnt;
                out_valid_d = 1'b1;
                out_data_d  = mux_data;
                out_src_d   = gidx;
                ptr_d       = (gidx == SRC_W'(N_REQ - 1)) ? '0 : gidx + SRC_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the datapath register is reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N_REQ=4, WIDTH=8): reset, rotation, skip/wrap,
// backpressure, idle and mid-operation reset, with hand-computed expectations.
module tb_rr_mux_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d [N_REQ];
    int         n_checks = 0;
    int         n_errors = 0;

    rr_mux_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    rr_mux_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_data = {d[3], d[2], d[1], d[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] src,
                             input logic [7:0] data);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_src"},   32'(bus.out_src),   32'(src));
        check({tag, "_data"},  32'(bus.out_data),  32'(data));
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) d[i] = 8'hA0 + 8'(i);
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset held two cycles with every requester valid.
        tick();
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check_out("rst", 1'b0, 2'd0, 8'h00);

        // Round robin: all valid, downstream always ready.
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("rr%0d_ready", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 8'hA0 + 8'(k % 4));
        end

        // Skip/wrap: grant 2 with data 5C, then only 1 and 2 valid from ptr=3.
        d[2]          = 8'h5C;
        bus.req_valid = 4'b0100;
        #1 check("sk0_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check_out("sk0", 1'b1, 2'd2, 8'h5C);
        bus.req_valid = 4'b0110;
        #1 check("sk1_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        check_out("sk1", 1'b1, 2'd1, 8'hA1);
        #1 check("sk2_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check_out("sk2", 1'b1, 2'd2, 8'h5C);

        // Backpressure: item from requester 2 holds for 3 cycles, no grants.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 2'd2, 8'h5C);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        check_out("bp_release", 1'b1, 2'd3, 8'hA3);

        // Idle: drain with no requests, pointer must hold at 0.
        bus.req_valid = 4'b0000;
        #1 check("idle_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_out("idle", 1'b0, 2'd3, 8'hA3);
        bus.req_valid = 4'b1111;
        #1 check("idle_ptr_ready", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = 4'b1000;
        #1 check("single3_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        check_out("single3", 1'b1, 2'd3, 8'hA3);

        // Move ptr away from 0, then reset during a stall.
        bus.req_valid = 4'b0010;
        #1 check("pre_rst_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        check_out("pre_rst", 1'b1, 2'd1, 8'hA1);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        rst           = 1'b1;
        #1 check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_out("mid_rst", 1'b0, 2'd0, 8'h00);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1 check("post_rst_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        check_out("post_rst", 1'b1, 2'd0, 8'hA0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
